// File: rtl/alu_cmd_responder_if.sv
// alu_cmd_responder_if
//   Bundles the UART byte interfaces and the ALU operand/result lines used by
//   alu_cmd_responder.
//   slave  : the responder side (receives bytes and ALU results, drives
//            tx_data/tx_start, ALU operands/opcode, busy and err).
//   master : the surrounding system (UART RX/TX and the ALU).
//   Signals:
//     rx_data[7:0], rx_valid        received byte + one-cycle strobe
//     tx_data[7:0], tx_start        byte to send + one-cycle request
//     tx_busy                       transmitter busy
//     alu_a, alu_b[7:0], alu_sel[2:0]  ALU operands / opcode
//     alu_result[31:0], alu_rem[7:0], alu_zflag, alu_div_ready  ALU outputs
//     busy, err                     responder status
interface alu_cmd_responder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_result;
  logic [7:0]  alu_rem;
  logic        alu_zflag;
  logic        alu_div_ready;
  logic        busy;
  logic        err;

  modport slave (
    input  rx_data, rx_valid, tx_busy, alu_result, alu_rem, alu_zflag, alu_div_ready,
    output tx_data, tx_start, alu_a, alu_b, alu_sel, busy, err
  );

  modport master (
    output rx_data, rx_valid, tx_busy, alu_result, alu_rem, alu_zflag, alu_div_ready,
    input  tx_data, tx_start, alu_a, alu_b, alu_sel, busy, err
  );
endinterface

// File: rtl/alu_cmd_responder.sv
// alu_cmd_responder
//   UART-side command responder for the ALU path. Assembles a 3-byte command
//   frame {header 10100ooo, A, B}, drives the ALU, captures the result and
//   streams a response {status, R[31:24], R[23:16], R[15:8], R[7:0]} back
//   through the UART transmitter.
//   Status byte: [7] zero result, [6] reserved opcode, [5] divide by zero,
//                [4] divide timeout, [3:0] payload byte count.
//   Ports:
//     clk    system clock
//     rst_n  synchronous active-low reset
//     bus    alu_cmd_responder_if.slave (UART RX/TX bytes, ALU lines, busy, err)
//   Parameters:
//     EXEC_WAIT     cycles operands are held before a non-divide capture (>= 1)
//     BYTE_TIMEOUT  idle cycles allowed between command bytes
//     DIV_TIMEOUT   cycles allowed waiting for alu_div_ready
//   Build option:
//     ALU_RSP_REM_EN  when defined, divide responses append alu_rem as a sixth
//                     byte and report a payload count of 5.
module alu_cmd_responder #(
  parameter int unsigned EXEC_WAIT    = 2,
  parameter int unsigned BYTE_TIMEOUT = 50000,
  parameter int unsigned DIV_TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_responder_if.slave   bus
);

`ifdef ALU_RSP_REM_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  localparam int unsigned CMAX0 = (BYTE_TIMEOUT > DIV_TIMEOUT) ? BYTE_TIMEOUT : DIV_TIMEOUT;
  localparam int unsigned CMAX  = (CMAX0 > EXEC_WAIT) ? CMAX0 : EXEC_WAIT;
  localparam int unsigned CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic [31:0]   res_q, res_d;
  logic [7:0]    rem_q, rem_d;
  logic          z_q, z_d;
  logic          dz_q, dz_d;
  logic          to_q, to_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          err_q, err_d;

  logic          is_div;
  logic          rsv;
  logic [2:0]    rsp_last;
  logic [7:0]    status;
  logic [7:0]    rsp_byte;

  assign is_div   = (sel_q == 3'b100);
  assign rsv      = (sel_q == 3'b011) || (sel_q == 3'b101) ||
                    (sel_q == 3'b110) || (sel_q == 3'b111);
  // Payload count equals the index of the last response byte.
  assign rsp_last = (REM_EN && is_div) ? 3'd5 : 3'd4;
  assign status   = {z_q, rsv, dz_q, to_q, 1'b0, rsp_last};

  // Index 5 (remainder) is only reachable when rsp_last is 5.
  always_comb begin
    rsp_byte = rem_q;
    case (idx_q)
      3'd0:    rsp_byte = status;
      3'd1:    rsp_byte = res_q[31:24];
      3'd2:    rsp_byte = res_q[23:16];
      3'd3:    rsp_byte = res_q[15:8];
      3'd4:    rsp_byte = res_q[7:0];
      default: rsp_byte = rem_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    rem_d      = rem_q;
    z_d        = z_q;
    dz_d       = dz_q;
    to_d       = to_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data[7:3] == 5'b10100) begin
            sel_d   = bus.rx_data[2:0];
            cnt_d   = '0;
            dz_d    = 1'b0;
            to_d    = 1'b0;
            state_d = S_GET_A;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_GET_A, S_GET_B: begin
        if (bus.rx_valid) begin
          cnt_d = '0;
          if (state_q == S_GET_A) begin
            a_d     = bus.rx_data;
            state_d = S_GET_B;
          end else begin
            b_d     = bus.rx_data;
            state_d = S_EXEC;
          end
        end else if (cnt_q == CW'(BYTE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div) begin
          if (b_q == '0) begin
            res_d   = '0;
            rem_d   = '0;
            z_d     = 1'b1;
            dz_d    = 1'b1;
            state_d = S_SEND;
          end else if (bus.alu_div_ready) begin
            res_d   = bus.alu_result;
            rem_d   = bus.alu_rem;
            z_d     = (bus.alu_result == '0);
            state_d = S_SEND;
          end else if (cnt_q == CW'(DIV_TIMEOUT - 1)) begin
            res_d   = '0;
            rem_d   = '0;
            z_d     = 1'b1;
            to_d    = 1'b1;
            err_d   = 1'b1;
            state_d = S_SEND;
          end
        end else if (cnt_q == CW'(EXEC_WAIT - 1)) begin
          // The ALU zero flag describes exactly the result captured here.
          res_d   = bus.alu_result;
          z_d     = bus.alu_zflag;
          state_d = S_SEND;
        end
        if (state_d == S_SEND) begin
          idx_d = '0;
          cnt_d = '0;
        end
      end

      S_SEND: begin
        if (!bus.tx_busy) begin
          tx_data_d  = rsp_byte;
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_WAIT_TX;
        end
      end

      S_WAIT_TX: begin
        // tx_busy only rises the cycle after tx_start, so the first cycle
        // here must not be read as "byte done".
        if (cnt_q == '0) begin
          cnt_d = CW'(1);
        end else if (!bus.tx_busy) begin
          if (idx_q == rsp_last) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SEND;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Bytes arriving while a response is in flight are dropped.
    if (bus.rx_valid && (state_q == S_EXEC || state_q == S_SEND || state_q == S_WAIT_TX)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      rem_q      <= '0;
      z_q        <= 1'b0;
      dz_q       <= 1'b0;
      to_q       <= 1'b0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      rem_q      <= rem_d;
      z_q        <= z_d;
      dz_q       <= dz_d;
      to_q       <= to_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.alu_sel  = sel_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_alu_cmd_responder.sv
module tb_alu_cmd_responder;
  localparam int unsigned EW = 2;
  localparam int unsigned BT = 50000;
  localparam int unsigned DT = 64;
  localparam int TXLEN = 4;

`ifdef ALU_RSP_REM_EN
  localparam bit REM = 1'b1;
`else
  localparam bit REM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_responder_if bus ();

  alu_cmd_responder #(
    .EXEC_WAIT   (EW),
    .BYTE_TIMEOUT(BT),
    .DIV_TIMEOUT (DT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] txq[$];
  int   err_cnt = 0;
  int   long_start = 0;
  int   start_busy = 0;
  logic prev_start = 1'b0;
  int   busy_left = 0;
  bit   start_seen = 1'b0;

  logic div_arm = 1'b0;
  logic div_ready = 1'b0;
  int   div_cnt = 0;
  int   div_delay = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ALU model: 0 add, 1 sub, 2 and, 3 xor, 4 div, 5 or, 6 mul, 7 shl
  logic [31:0] m_a, m_b, m_r;
  always_comb begin
    m_a = {24'd0, bus.alu_a};
    m_b = {24'd0, bus.alu_b};
    m_r = '0;
    case (bus.alu_sel)
      3'd0: m_r = m_a + m_b;
      3'd1: m_r = m_a - m_b;
      3'd2: m_r = m_a & m_b;
      3'd3: m_r = m_a ^ m_b;
      3'd4: m_r = (div_ready && m_b != 0) ? m_a / m_b : 32'd0;
      3'd5: m_r = m_a | m_b;
      3'd6: m_r = m_a * m_b;
      default: m_r = m_a << m_b[4:0];
    endcase
    bus.alu_result    = m_r;
    bus.alu_zflag     = (m_r == 32'd0);
    bus.alu_div_ready = div_ready;
    bus.alu_rem       = (div_ready && m_b != 0) ? 8'(m_a % m_b) : 8'd0;
  end

  // Divider latency model
  always @(negedge clk) begin
    if (!div_arm) begin
      div_ready = 1'b0;
      div_cnt   = 0;
    end else if (div_cnt >= div_delay) begin
      div_ready = 1'b1;
    end else begin
      div_cnt++;
    end
  end

  // UART TX model and output monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.tx_busy = 1'b0;
      busy_left   = 0;
      start_seen  = 1'b0;
      prev_start  = 1'b0;
    end else begin
      if (start_seen) begin
        bus.tx_busy = 1'b1;
        busy_left   = TXLEN;
        start_seen  = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.tx_busy = 1'b0;
      end
      if (bus.tx_start) begin
        if (prev_start) long_start++;
        if (bus.tx_busy && busy_left != TXLEN) start_busy++;
        txq.push_back(bus.tx_data);
        start_seen = 1'b1;
      end
      prev_start = bus.tx_start;
    end
    if (bus.err) err_cnt++;
  end

  typedef struct {
    logic [7:0]  hdr;
    logic [7:0]  a;
    logic [7:0]  b;
    int          delay;   // divider latency, -1 = not armed
    logic [47:0] exp;     // expected bytes, byte 0 in [47:40]
    int          n;
    int          errs;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b,
                              input int d, input logic [47:0] e, input int n, input int errs);
    vec_t v;
    v.hdr = h; v.a = a; v.b = b; v.delay = d; v.exp = e; v.n = n; v.errs = errs;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (txq.size() >= n && !bus.busy) break;
    end
    repeat (10) @(negedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input logic [47:0] e, input int n);
    logic [7:0] got;
    check({tag, "_count"}, txq.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < txq.size()) ? txq[i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, e[47-8*i -: 8]});
    end
  endtask

  vec_t vecs[11];
  int   e0;
  int   m;
  bit   got_err;
  bit   rst_ok;

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;

    vecs[0]  = mk(8'hA0, 8'h05, 8'h03, -1,   48'h04_00_00_00_08_00, 5, 0);
    vecs[1]  = mk(8'hA3, 8'h07, 8'h07, -1,   48'hC4_00_00_00_00_00, 5, 0);
    vecs[2]  = mk(8'hA4, 8'h11, 8'h04, 10,
                  REM ? 48'h05_00_00_00_04_01 : 48'h04_00_00_00_04_00, REM ? 6 : 5, 0);
    vecs[3]  = mk(8'hA4, 8'h09, 8'h00, 1000,
                  REM ? 48'hA5_00_00_00_00_00 : 48'hA4_00_00_00_00_00, REM ? 6 : 5, 0);
    vecs[4]  = mk(8'hA1, 8'h10, 8'h03, -1,   48'h04_00_00_00_0D_00, 5, 0);
    vecs[5]  = mk(8'hA6, 8'h10, 8'h10, -1,   48'h44_00_00_01_00_00, 5, 0);
    vecs[6]  = mk(8'hA7, 8'hFF, 8'h03, -1,   48'h44_00_00_07_F8_00, 5, 0);
    vecs[7]  = mk(8'hA5, 8'hF0, 8'h0F, -1,   48'h44_00_00_00_FF_00, 5, 0);
    vecs[8]  = mk(8'hA2, 8'hF0, 8'h0F, -1,   48'h84_00_00_00_00_00, 5, 0);
    vecs[9]  = mk(8'hA4, 8'h11, 8'h04, 1000,
                  REM ? 48'h95_00_00_00_00_00 : 48'h94_00_00_00_00_00, REM ? 6 : 5, 1);
    vecs[10] = mk(8'hA4, 8'hC8, 8'h07, 3,
                  REM ? 48'h05_00_00_00_1C_04 : 48'h04_00_00_00_1C_00, REM ? 6 : 5, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'd0, bus.tx_start}, 0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_err", {31'd0, bus.err}, 0);
    check("rst_alu_a", {24'd0, bus.alu_a}, 0);
    check("rst_alu_b", {24'd0, bus.alu_b}, 0);
    check("rst_alu_sel", {29'd0, bus.alu_sel}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 11; i++) begin
      e0 = err_cnt;
      txq.delete();
      send_byte(vecs[i].hdr);
      check($sformatf("v%0d_busy", i), {31'd0, bus.busy}, 1);
      send_byte(vecs[i].a);
      send_byte(vecs[i].b);
      if (vecs[i].delay >= 0) begin
        div_delay = vecs[i].delay;
        div_arm   = 1'b1;
      end
      wait_resp(vecs[i].n);
      div_arm = 1'b0;
      check($sformatf("v%0d_sel", i), {29'd0, bus.alu_sel}, {29'd0, vecs[i].hdr[2:0]});
      check($sformatf("v%0d_a", i), {24'd0, bus.alu_a}, {24'd0, vecs[i].a});
      check($sformatf("v%0d_b", i), {24'd0, bus.alu_b}, {24'd0, vecs[i].b});
      check_frame($sformatf("v%0d", i), vecs[i].exp, vecs[i].n);
      check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].errs);
      repeat (2) @(negedge clk);
    end

    // Bad header
    e0 = err_cnt;
    txq.delete();
    send_byte(8'h3C);
    check("badhdr_busy", {31'd0, bus.busy}, 0);
    repeat (20) @(negedge clk);
    #1;
    check("badhdr_tx", txq.size(), 0);
    check("badhdr_err", err_cnt - e0, 1);

    // Inter-byte timeout
    e0 = err_cnt;
    txq.delete();
    send_byte(8'hA0);
    send_byte(8'h01);
    m = 0;
    got_err = 1'b0;
    while (m < int'(BT) + 20 && !got_err) begin
      @(negedge clk);
      m++;
      if (bus.err) got_err = 1'b1;
    end
    check("bto_err_seen", {31'd0, got_err}, 1);
    check("bto_window", {31'd0, (m >= int'(BT) - 2 && m <= int'(BT) + 2)}, 1);
    repeat (3) @(negedge clk);
    #1;
    check("bto_busy", {31'd0, bus.busy}, 0);
    check("bto_err_count", err_cnt - e0, 1);
    check("bto_alu_a", {24'd0, bus.alu_a}, 32'h01);
    check("bto_alu_b", {24'd0, bus.alu_b}, 32'h07);
    check("bto_tx", txq.size(), 0);

    // Byte received while the response is being transmitted
    e0 = err_cnt;
    txq.delete();
    send_byte(8'hA0);
    send_byte(8'h05);
    send_byte(8'h03);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (txq.size() >= 1) break;
    end
    send_byte(8'h55);
    wait_resp(5);
    check_frame("rxbusy", 48'h04_00_00_00_08_00, 5);
    check("rxbusy_err", err_cnt - e0, 1);

    // Reset during the third response byte
    e0 = err_cnt;
    txq.delete();
    send_byte(8'hA0);
    send_byte(8'h05);
    send_byte(8'h03);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk); #1;
      if (txq.size() >= 3) break;
    end
    check("rstmid_reached", txq.size(), 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("rstmid_tx_start", {31'd0, bus.tx_start}, 0);
    check("rstmid_tx_data", {24'd0, bus.tx_data}, 0);
    check("rstmid_busy", {31'd0, bus.busy}, 0);
    check("rstmid_err", {31'd0, bus.err}, 0);
    check("rstmid_alu", {13'd0, bus.alu_sel, bus.alu_a, bus.alu_b}, 0);
    rst_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.tx_start) rst_ok = 1'b0;
    end
    check("rstmid_hold", {31'd0, rst_ok}, 1);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("rstmid_no_more_tx", txq.size(), 3);
    check("rstmid_idle", {31'd0, bus.busy}, 0);

    // Fresh frame after reset
    txq.delete();
    send_byte(8'hA0);
    send_byte(8'h05);
    send_byte(8'h03);
    wait_resp(5);
    check_frame("postrst", 48'h04_00_00_00_08_00, 5);
    check("postrst_err", err_cnt - e0, 0);

    check("tx_start_width", long_start, 0);
    check("tx_start_while_busy", start_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
